// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg. The master drives the control and data inputs.
// The slave (the register) drives the registered outputs back.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             s_in_r;
    logic             s_in_l;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] p_out;
    logic             s_out_r;
    logic             s_out_l;
    logic [CW-1:0]    shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, s_in_r, s_in_l, p_in,
        input  p_out, s_out_r, s_out_l, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, s_in_r, s_in_l, p_in,
        output p_out, s_out_r, s_out_l, shift_cnt, word_done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load, with a clock enable.
// A shared shift counter pulses word_done once every WIDTH shifts.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    univ_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_d;

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_d = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: ;
                MODE_RIGHT: begin
                    q_d     = {bus.s_in_r, q_q[WIDTH-1:1]};
                    shift_d = 1'b1;
                end
                MODE_LEFT: begin
                    q_d     = {q_q[WIDTH-2:0], bus.s_in_l};
                    shift_d = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = bus.p_in;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Both directions advance the same counter; the wrap edge raises the pulse.
        if (shift_d) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.p_out     = q_q;
    assign bus.s_out_r   = q_q[0];
    assign bus.s_out_l   = q_q[WIDTH-1];
    assign bus.shift_cnt = cnt_q;
    assign bus.word_done = done_q;
endmodule
